// File: rtl/muldiv_arbiter_if.sv
// Bundle between the dual-issue EX lanes / MDU and the mult-div arbiter.
// master = pipeline + MDU side, slave = arbiter.
interface muldiv_arbiter_if #(
    parameter int CNT_W = 32
);
    logic             flush;
    logic             stall_i;
    logic             req_i1;
    logic [1:0]       op_i1;
    logic [31:0]      a_i1;
    logic [31:0]      b_i1;
    logic             req_i2;
    logic [1:0]       op_i2;
    logic [31:0]      a_i2;
    logic [31:0]      b_i2;
    logic             md_start;
    logic [1:0]       md_op;
    logic [31:0]      md_a;
    logic [31:0]      md_b;
    logic             md_cancel;
    logic             md_done;
    logic [31:0]      md_hi;
    logic [31:0]      md_lo;
    logic             stallreq;
    logic             res_valid_i1;
    logic [31:0]      hi_i1;
    logic [31:0]      lo_i1;
    logic             res_valid_i2;
    logic [31:0]      hi_i2;
    logic [31:0]      lo_i2;
    logic             err_timeout;
    logic [CNT_W-1:0] busy_cnt;

    modport master (
        output flush, stall_i,
        output req_i1, op_i1, a_i1, b_i1,
        output req_i2, op_i2, a_i2, b_i2,
        output md_done, md_hi, md_lo,
        input  md_start, md_op, md_a, md_b, md_cancel,
        input  stallreq, res_valid_i1, hi_i1, lo_i1,
        input  res_valid_i2, hi_i2, lo_i2, err_timeout, busy_cnt
    );

    modport slave (
        input  flush, stall_i,
        input  req_i1, op_i1, a_i1, b_i1,
        input  req_i2, op_i2, a_i2, b_i2,
        input  md_done, md_hi, md_lo,
        output md_start, md_op, md_a, md_b, md_cancel,
        output stallreq, res_valid_i1, hi_i1, lo_i1,
        output res_valid_i2, hi_i2, lo_i2, err_timeout, busy_cnt
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Serialises lane-1/lane-2 mult/div ops onto one shared MDU, holds the pipe while
// busy, presents per-lane HI/LO, aborts on flush and watchdogs hung MDU ops.
//
// state  | meaning
// IDLE   | no op captured; accepts a new request
// ISSUE1 | start pulse with lane-1 op
// WAIT1  | waiting for MDU result of lane 1
// ISSUE2 | start pulse with lane-2 op
// WAIT2  | waiting for MDU result of lane 2
// HOLD   | results presented until EX advances
module muldiv_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input logic             clk,
    input logic             rst,
    muldiv_arbiter_if.slave bus
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             cap_req1_q, cap_req2_q;
    logic [1:0]       cap_op1_q, cap_op2_q;
    logic [31:0]      cap_a1_q, cap_b1_q, cap_a2_q, cap_b2_q;
    logic [31:0]      hi1_q, lo1_q, hi2_q, lo2_q;
    logic [WD_W-1:0]  wd_q;
    logic             err_q;
    logic [CNT_W-1:0] busy_q;

    logic        in_wait;
    logic        in_busy;
    logic        timeout;
    logic        any_req;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        md_cancel;
    logic        stallreq;

    assign in_wait = (state_q == WAIT1) || (state_q == WAIT2);
    assign in_busy = in_wait || (state_q == ISSUE1) || (state_q == ISSUE2);
    assign any_req = bus.req_i1 || bus.req_i2;
    // Watchdog is a down-counter loaded at issue; terminal count in WAIT without done is a hang.
    assign timeout = in_wait && !bus.md_done && (wd_q == '0);

    always_comb begin
        state_d   = state_q;
        md_start  = 1'b0;
        md_op     = 2'b00;
        md_a      = 32'd0;
        md_b      = 32'd0;
        md_cancel = 1'b0;
        stallreq  = 1'b0;
        case (state_q)
            IDLE: begin
                stallreq = any_req;
                if (any_req)
                    state_d = bus.req_i1 ? ISSUE1 : ISSUE2;
            end
            ISSUE1: begin
                stallreq = 1'b1;
                md_start = 1'b1;
                md_op    = cap_op1_q;
                md_a     = cap_a1_q;
                md_b     = cap_b1_q;
                state_d  = WAIT1;
            end
            WAIT1: begin
                stallreq = 1'b1;
                if (bus.md_done)
                    state_d = cap_req2_q ? ISSUE2 : HOLD;
                else if (timeout) begin
                    md_cancel = 1'b1;
                    state_d   = HOLD;
                end
            end
            ISSUE2: begin
                stallreq = 1'b1;
                md_start = 1'b1;
                md_op    = cap_op2_q;
                md_a     = cap_a2_q;
                md_b     = cap_b2_q;
                state_d  = WAIT2;
            end
            WAIT2: begin
                stallreq = 1'b1;
                if (bus.md_done)
                    state_d = HOLD;
                else if (timeout) begin
                    md_cancel = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!bus.stall_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A start squashed by flush never reaches the MDU, so only WAIT needs a cancel.
        if (bus.flush) begin
            state_d   = IDLE;
            md_start  = 1'b0;
            md_cancel = in_wait;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cap_req1_q <= 1'b0;
            cap_req2_q <= 1'b0;
            cap_op1_q  <= 2'b00;
            cap_op2_q  <= 2'b00;
            cap_a1_q   <= 32'd0;
            cap_b1_q   <= 32'd0;
            cap_a2_q   <= 32'd0;
            cap_b2_q   <= 32'd0;
            hi1_q      <= 32'd0;
            lo1_q      <= 32'd0;
            hi2_q      <= 32'd0;
            lo2_q      <= 32'd0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            busy_q     <= '0;
        end else begin
            state_q <= state_d;
            if (in_busy)
                busy_q <= busy_q + 1'b1;
            if (bus.flush) begin
                cap_req1_q <= 1'b0;
                cap_req2_q <= 1'b0;
                hi1_q      <= 32'd0;
                lo1_q      <= 32'd0;
                hi2_q      <= 32'd0;
                lo2_q      <= 32'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_req) begin
                            cap_req1_q <= bus.req_i1;
                            cap_op1_q  <= bus.op_i1;
                            cap_a1_q   <= bus.a_i1;
                            cap_b1_q   <= bus.b_i1;
                            cap_req2_q <= bus.req_i2;
                            cap_op2_q  <= bus.op_i2;
                            cap_a2_q   <= bus.a_i2;
                            cap_b2_q   <= bus.b_i2;
                            hi1_q      <= 32'd0;
                            lo1_q      <= 32'd0;
                            hi2_q      <= 32'd0;
                            lo2_q      <= 32'd0;
                        end
                    end
                    ISSUE1, ISSUE2: wd_q <= WD_W'(TIMEOUT - 1);
                    WAIT1: begin
                        if (bus.md_done) begin
                            hi1_q <= bus.md_hi;
                            lo1_q <= bus.md_lo;
                        end else if (timeout) begin
                            hi1_q <= 32'd0;
                            lo1_q <= 32'd0;
                            err_q <= 1'b1;
                        end else
                            wd_q <= wd_q - 1'b1;
                    end
                    WAIT2: begin
                        if (bus.md_done) begin
                            hi2_q <= bus.md_hi;
                            lo2_q <= bus.md_lo;
                        end else if (timeout) begin
                            hi2_q <= 32'd0;
                            lo2_q <= 32'd0;
                            err_q <= 1'b1;
                        end else
                            wd_q <= wd_q - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.md_start     = md_start;
    assign bus.md_op        = md_op;
    assign bus.md_a         = md_a;
    assign bus.md_b         = md_b;
    assign bus.md_cancel    = md_cancel;
    assign bus.stallreq     = stallreq;
    assign bus.res_valid_i1 = (state_q == HOLD) && cap_req1_q;
    assign bus.res_valid_i2 = (state_q == HOLD) && cap_req2_q;
    assign bus.hi_i1        = bus.res_valid_i1 ? hi1_q : 32'd0;
    assign bus.lo_i1        = bus.res_valid_i1 ? lo1_q : 32'd0;
    assign bus.hi_i2        = bus.res_valid_i2 ? hi2_q : 32'd0;
    assign bus.lo_i2        = bus.res_valid_i2 ? lo2_q : 32'd0;
    assign bus.err_timeout  = err_q;
    assign bus.busy_cnt     = busy_q;
endmodule
